// File: rtl/cpu_defs.sv
// Shared widths and register-name constants for the MIPS datapath.
package cpu_defs;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for in-flight long-latency ops and RAW stall generation.
module reg_scoreboard
    import cpu_defs::*;
#(
    parameter int SB_ADDR_W   = cpu_defs::ADDR_W,
    parameter int SB_NUM_REGS = cpu_defs::NUM_REGS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SB_ADDR_W-1:0]   rs_addr,
    input  logic [SB_ADDR_W-1:0]   rt_addr,
    input  logic                   rs_use,
    input  logic                   rt_use,
    input  logic                   wr_en,
    input  logic [SB_ADDR_W-1:0]   wr_addr,
    input  logic                   issue_en,
    input  logic [SB_ADDR_W-1:0]   issue_addr,
    output logic                   stall,
    output logic [SB_NUM_REGS-1:0] pending
);

    logic haz_a;
    logic haz_b;
    logic issue_ok;
    logic clear_ok;

    // A write-back landing this cycle is bypassed to decode, so it resolves the hazard.
    assign haz_a    = rs_use && pending[rs_addr] && !(wr_en && (wr_addr == rs_addr));
    assign haz_b    = rt_use && pending[rt_addr] && !(wr_en && (wr_addr == rt_addr));
    assign stall    = haz_a | haz_b;
    assign issue_ok = issue_en && !stall && (issue_addr != REG_ZERO);
    assign clear_ok = wr_en && (wr_addr != REG_ZERO);

    // The set follows the clear so a same-index collision leaves the new producer outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (clear_ok) begin
                pending[wr_addr] <= 1'b0;
            end
            if (issue_ok) begin
                pending[issue_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// MIPS architectural register file: two bypassed combinational read ports,
// one write-back port, and a pending scoreboard that stalls decode on RAW hazards.
module reg_file_scoreboard
    import cpu_defs::*;
#(
    parameter int DATA_W   = cpu_defs::DATA_W,
    parameter int ADDR_W   = cpu_defs::ADDR_W,
    parameter int NUM_REGS = cpu_defs::NUM_REGS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rs_addr,
    input  logic [ADDR_W-1:0]   rt_addr,
    input  logic                rs_use,
    input  logic                rt_use,
    output logic [DATA_W-1:0]   rs_data,
    output logic [DATA_W-1:0]   rt_data,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != REG_ZERO)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == REG_ZERO) begin
            rs_data = '0;
        end else if (wr_en && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == REG_ZERO) begin
            rt_data = '0;
        end else if (wr_en && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end
    end

    reg_scoreboard #(
        .SB_ADDR_W   (ADDR_W),
        .SB_NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_use     (rs_use),
        .rt_use     (rt_use),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .stall      (stall),
        .pending    (pending)
    );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard; expected values queued at drive time, popped at check time.
module tb_reg_file_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_use;
    logic        rt_use;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        stall;
    logic [31:0] pending;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    reg_file_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_use     (rs_use),
        .rt_use     (rt_use),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .stall      (stall),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, expected queue empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
        rs_use   = 1'b0;
        rt_use   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rs_addr = '0; rt_addr = '0; rs_use = 1'b0; rt_use = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; issue_en = 1'b0; issue_addr = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1: post-reset reads of every index are zero
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            settle();
            expect_val(32'h0); check("reset_rs", rs_data);
            expect_val(32'h0); check("reset_rt", rt_data);
        end
        expect_val(32'h0); check("reset_pending", pending);
        expect_val(32'h0); check("reset_stall", {31'b0, stall});

        // 2: plain write then read; r0 write discarded
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle(); rs_addr = 5'd5;
        settle();
        expect_val(32'hDEADBEEF); check("write_r5", rs_data);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs_addr = 5'd0; rt_addr = 5'd0;
        settle();
        expect_val(32'h0); check("r0_no_bypass", rs_data);
        tick();
        idle();
        settle();
        expect_val(32'h0); check("r0_rs", rs_data);
        expect_val(32'h0); check("r0_rt", rt_data);

        // 3: write-through bypass before the edge
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rt_addr = 5'd7;
        settle();
        expect_val(32'hA5A5A5A5); check("bypass_rt", rt_data);
        tick();
        idle();
        settle();
        expect_val(32'hA5A5A5A5); check("stored_r7", rt_data);

        // 4: issue r9, RAW stall, resolved by same-cycle write-back
        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        idle(); rs_addr = 5'd9; rs_use = 1'b1;
        settle();
        expect_val(32'h1); check("raw_stall", {31'b0, stall});
        expect_val(32'h1 << 9); check("pending_r9", pending);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_9999;
        settle();
        expect_val(32'h0); check("wb_resolves_stall", {31'b0, stall});
        expect_val(32'h0000_9999); check("wb_bypass_rs", rs_data);
        tick();
        idle();
        settle();
        expect_val(32'h0); check("pending_r9_clear", pending);

        // rt port hazard, and an unused pending source does not stall
        issue_en = 1'b1; issue_addr = 5'd12;
        tick();
        idle(); rt_addr = 5'd12; rt_use = 1'b1;
        settle();
        expect_val(32'h1); check("raw_stall_rt", {31'b0, stall});
        rt_use = 1'b0; rs_addr = 5'd12;
        settle();
        expect_val(32'h0); check("unused_no_stall", {31'b0, stall});

        // 5: issue/write-back collision on r3: data written and pending set
        issue_en = 1'b1; issue_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3333_0003;
        tick();
        idle(); rs_addr = 5'd3;
        settle();
        expect_val(32'h3333_0003); check("collision_data", rs_data);
        expect_val((32'h1 << 3) | (32'h1 << 12)); check("collision_pending", pending);

        // issue while stalled is dropped
        rt_addr = 5'd12; rt_use = 1'b1; issue_en = 1'b1; issue_addr = 5'd20;
        settle();
        expect_val(32'h1); check("stall_for_drop", {31'b0, stall});
        tick();
        idle();
        settle();
        expect_val((32'h1 << 3) | (32'h1 << 12)); check("issue_dropped", pending);

        // issue to r0 ignored; re-issue of pending r3 keeps it set
        issue_en = 1'b1; issue_addr = 5'd0;
        tick();
        issue_addr = 5'd3;
        tick();
        idle();
        settle();
        expect_val((32'h1 << 3) | (32'h1 << 12)); check("r0_and_reissue", pending);

        // 6: pending r4, write non-pending r10, then reset overriding write and issue
        issue_en = 1'b1; issue_addr = 5'd4;
        tick();
        idle(); wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h55;
        tick();
        idle(); rs_addr = 5'd10;
        settle();
        expect_val(32'h55); check("write_r10", rs_data);
        expect_val((32'h1 << 3) | (32'h1 << 4) | (32'h1 << 12)); check("nonpending_write", pending);

        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hFFFF_0011;
        issue_en = 1'b1; issue_addr = 5'd6;
        tick();
        reset = 1'b0; idle();
        rs_addr = 5'd10; rt_addr = 5'd4; rt_use = 1'b1;
        settle();
        expect_val(32'h0); check("reset2_pending", pending);
        expect_val(32'h0); check("reset2_r10", rs_data);
        expect_val(32'h0); check("reset2_stall", {31'b0, stall});
        rs_addr = 5'd11;
        settle();
        expect_val(32'h0); check("reset2_r11", rs_data);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
